// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: registered ALU-control decode between ID and the ID/EX register.
// Decodes alu_op/funct into an ALU operation code behind a valid/ready handshake,
// with flush and a MULT/DIV busy sequencer that stalls HI/LO-dependent ops.
// Optional feature macro: ALUCTRL_MULDIV_EN (MULT/DIV/MFHI/MFLO decode + busy FSM).
module alu_ctrl_stage #(
    parameter int unsigned FUNC_W        = 6,
    parameter int unsigned CTRL_W        = 4,
    parameter int unsigned MULDIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_op,
    input  logic [FUNC_W-1:0] func,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_control,
    output logic              illegal,
    output logic              muldiv_busy
);

    localparam int unsigned CODE_W = 4;

    localparam logic [CODE_W-1:0] C_AND  = 4'b0000;
    localparam logic [CODE_W-1:0] C_OR   = 4'b0001;
    localparam logic [CODE_W-1:0] C_ADD  = 4'b0010;
    localparam logic [CODE_W-1:0] C_XOR  = 4'b0011;
    localparam logic [CODE_W-1:0] C_SUB  = 4'b0110;
    localparam logic [CODE_W-1:0] C_SLT  = 4'b0111;
    localparam logic [CODE_W-1:0] C_SLL  = 4'b1000;
    localparam logic [CODE_W-1:0] C_SRL  = 4'b1001;
    localparam logic [CODE_W-1:0] C_SRA  = 4'b1010;
    localparam logic [CODE_W-1:0] C_LUI  = 4'b1011;
    localparam logic [CODE_W-1:0] C_NOR  = 4'b1100;
`ifdef ALUCTRL_MULDIV_EN
    localparam logic [CODE_W-1:0] C_MFHI = 4'b0100;
    localparam logic [CODE_W-1:0] C_MFLO = 4'b0101;
    localparam logic [CODE_W-1:0] C_MULT = 4'b1101;
    localparam logic [CODE_W-1:0] C_DIV  = 4'b1110;
`endif

    logic [CODE_W-1:0] code_c;
    logic              illegal_c;
    logic              is_hilo_c;
    logic              is_muldiv_c;
    logic              in_ready_c;
    logic              accept_c;

    logic              out_valid_q;
    logic [CTRL_W-1:0] alu_control_q;
    logic              illegal_q;

    // Combinational decode of the offered instruction
    always_comb begin
        code_c      = C_ADD;
        illegal_c   = 1'b0;
        is_hilo_c   = 1'b0;
        is_muldiv_c = 1'b0;
        case (alu_op)
            3'b000: code_c = C_ADD;
            3'b001: code_c = C_SUB;
            3'b011: code_c = C_AND;
            3'b100: code_c = C_OR;
            3'b101: code_c = C_SLT;
            3'b110: code_c = C_LUI;
            3'b111: code_c = C_XOR;
            default: begin
                case (func)
                    FUNC_W'(6'b100000), FUNC_W'(6'b100001): code_c = C_ADD;
                    FUNC_W'(6'b100010), FUNC_W'(6'b100011): code_c = C_SUB;
                    FUNC_W'(6'b100100): code_c = C_AND;
                    FUNC_W'(6'b100101): code_c = C_OR;
                    FUNC_W'(6'b100110): code_c = C_XOR;
                    FUNC_W'(6'b100111): code_c = C_NOR;
                    FUNC_W'(6'b101010): code_c = C_SLT;
                    FUNC_W'(6'b000000): code_c = C_SLL;
                    FUNC_W'(6'b000010): code_c = C_SRL;
                    FUNC_W'(6'b000011): code_c = C_SRA;
`ifdef ALUCTRL_MULDIV_EN
                    FUNC_W'(6'b010000): begin
                        code_c    = C_MFHI;
                        is_hilo_c = 1'b1;
                    end
                    FUNC_W'(6'b010010): begin
                        code_c    = C_MFLO;
                        is_hilo_c = 1'b1;
                    end
                    FUNC_W'(6'b011000), FUNC_W'(6'b011001): begin
                        code_c      = C_MULT;
                        is_hilo_c   = 1'b1;
                        is_muldiv_c = 1'b1;
                    end
                    FUNC_W'(6'b011010), FUNC_W'(6'b011011): begin
                        code_c      = C_DIV;
                        is_hilo_c   = 1'b1;
                        is_muldiv_c = 1'b1;
                    end
`endif
                    default: begin
                        code_c    = C_ADD;
                        illegal_c = 1'b1;
                    end
                endcase
            end
        endcase
    end

`ifdef ALUCTRL_MULDIV_EN
    localparam int unsigned CNT_W = (MULDIV_CYCLES >= 2) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             muldiv_start_c;

    // A flushed MULT/DIV never reaches EX, so it must not start the sequencer
    assign muldiv_start_c = accept_c && is_muldiv_c && !flush;
    assign in_ready_c     = (!out_valid_q || out_ready) && !(busy_q && is_hilo_c);
    assign muldiv_busy    = busy_q;

    // MULT/DIV sequencer: busy for MULDIV_CYCLES cycles after the accepting edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (muldiv_start_c) begin
                        state_q <= ST_BUSY;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
`else
    // Sequencer not built: HI/LO ops decode as illegal and nothing stalls
    logic unused_cfg;
    assign unused_cfg  = (MULDIV_CYCLES >= 32'd2) ^ is_hilo_c ^ is_muldiv_c;
    assign in_ready_c  = !out_valid_q || out_ready;
    assign muldiv_busy = 1'b0;
`endif

    assign accept_c = in_valid && in_ready_c;
    assign in_ready = in_ready_c;

    // Output register: flush beats load, load beats drain, otherwise hold
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            alu_control_q <= '0;
            illegal_q     <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept_c) begin
            out_valid_q   <= 1'b1;
            alu_control_q <= CTRL_W'(code_c);
            illegal_q     <= illegal_c;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_control = alu_control_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage (MULDIV_CYCLES=4); inputs change 1 time unit
// after posedge, DUT outputs are sampled on negedge.
module tb_alu_ctrl_stage;

    localparam int unsigned NCYC = 4;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] alu_op;
    logic [5:0] func;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] alu_control;
    logic       illegal;
    logic       muldiv_busy;

    alu_ctrl_stage #(
        .FUNC_W       (6),
        .CTRL_W       (4),
        .MULDIV_CYCLES(NCYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .func       (func),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_control(alu_control),
        .illegal    (illegal),
        .muldiv_busy(muldiv_busy)
    );

    typedef struct {
        logic [3:0] code;
        logic       ill;
        int         cyc;
        logic       lat;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [5:0] fn;
        logic [3:0] code;
        logic       ill;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every transfer to EX is matched against the oldest expectation
    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got code %0d with empty scoreboard", alu_control);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_code", int'(alu_control), int'(e.code));
                check("sb_illegal", int'(illegal), int'(e.ill));
                if (e.lat) check("sb_latency", cyc - e.cyc, 1);
            end
        end
    end

    // Offer one instruction until accepted; expectation pushed unless flushed
    task automatic issue(input logic [2:0] op, input logic [5:0] fn, input logic [3:0] ec,
                         input logic ei, input logic lat, input logic fl, output int waits);
        bit done;
        exp_t e;
        alu_op   = op;
        func     = fn;
        flush    = fl;
        in_valid = 1'b1;
        waits    = 0;
        done     = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                if (!fl) begin
                    e.code = ec;
                    e.ill  = ei;
                    e.cyc  = cyc;
                    e.lat  = lat;
                    exp_q.push_back(e);
                end
            end else begin
                waits++;
                if (waits > 40) begin
                    checks++;
                    failures++;
                    $display("FAIL accept_timeout: got no in_ready after %0d cycles, expected accept", waits);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic addv(input logic [2:0] op, input logic [5:0] fn, input logic [3:0] c,
                        input logic ill);
        vec_t v;
        v.op   = op;
        v.fn   = fn;
        v.code = c;
        v.ill  = ill;
        vecs.push_back(v);
    endtask

    initial begin
        int w;
        #100000;
        $display("FAIL watchdog: got simulation timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset     = 1'b1;
        in_valid  = 1'b1;
        alu_op    = 3'b010;
        func      = 6'b100010;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset held with a valid instruction offered
        repeat (2) begin
            @(negedge clk);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_alu_control", int'(alu_control), 0);
            check("rst_illegal", int'(illegal), 0);
            check("rst_muldiv_busy", int'(muldiv_busy), 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // First accept after reset: SUB, visible one cycle later
        issue(3'b010, 6'b100010, 4'b0110, 1'b0, 1'b1, 1'b0, w);

        // R-type sweep and non-R-type classes with EX always ready
        addv(3'b010, 6'b100000, 4'b0010, 1'b0);
        addv(3'b010, 6'b100001, 4'b0010, 1'b0);
        addv(3'b010, 6'b100010, 4'b0110, 1'b0);
        addv(3'b010, 6'b100011, 4'b0110, 1'b0);
        addv(3'b010, 6'b100100, 4'b0000, 1'b0);
        addv(3'b010, 6'b100101, 4'b0001, 1'b0);
        addv(3'b010, 6'b100110, 4'b0011, 1'b0);
        addv(3'b010, 6'b100111, 4'b1100, 1'b0);
        addv(3'b010, 6'b101010, 4'b0111, 1'b0);
        addv(3'b010, 6'b000000, 4'b1000, 1'b0);
        addv(3'b010, 6'b000010, 4'b1001, 1'b0);
        addv(3'b010, 6'b000011, 4'b1010, 1'b0);
        addv(3'b010, 6'b111111, 4'b0010, 1'b1);
`ifdef ALUCTRL_MULDIV_EN
        addv(3'b010, 6'b010000, 4'b0100, 1'b0);
        addv(3'b010, 6'b010010, 4'b0101, 1'b0);
`else
        addv(3'b010, 6'b010000, 4'b0010, 1'b1);
        addv(3'b010, 6'b010010, 4'b0010, 1'b1);
`endif
        addv(3'b000, 6'b111111, 4'b0010, 1'b0);
        addv(3'b001, 6'b000000, 4'b0110, 1'b0);
        addv(3'b011, 6'b100010, 4'b0000, 1'b0);
        addv(3'b100, 6'b000000, 4'b0001, 1'b0);
        addv(3'b101, 6'b111111, 4'b0111, 1'b0);
        addv(3'b110, 6'b000000, 4'b1011, 1'b0);
        addv(3'b111, 6'b011000, 4'b0011, 1'b0);
        foreach (vecs[i]) issue(vecs[i].op, vecs[i].fn, vecs[i].code, vecs[i].ill, 1'b1, 1'b0, w);

        // Back-pressure: SUB held while AND waits
        issue(3'b001, 6'b000000, 4'b0110, 1'b0, 1'b0, 1'b0, w);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_op    = 3'b011;
        func      = 6'b000000;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_alu_control", int'(alu_control), 6);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        issue(3'b011, 6'b000000, 4'b0000, 1'b0, 1'b1, 1'b0, w);
        check("bp_and_wait", w, 0);

        // Flush drops an OR accepted in the same cycle
        issue(3'b100, 6'b000000, 4'b0001, 1'b0, 1'b0, 1'b1, w);
        @(negedge clk);
        check("flush_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;

`ifdef ALUCTRL_MULDIV_EN
        // MULT then MFLO: MFLO stalls for the whole busy window
        issue(3'b010, 6'b011000, 4'b1101, 1'b0, 1'b1, 1'b0, w);
        in_valid = 1'b1;
        alu_op   = 3'b010;
        func     = 6'b010010;
        for (int k = 0; k < int'(NCYC); k++) begin
            @(negedge clk);
            check("mult_busy", int'(muldiv_busy), 1);
            check("mflo_in_ready", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        issue(3'b010, 6'b010010, 4'b0101, 1'b0, 1'b1, 1'b0, w);
        check("mflo_first_idle", w, 0);

        // DIV, ADD passes during busy, MFHI waits out the rest
        issue(3'b010, 6'b011010, 4'b1110, 1'b0, 1'b1, 1'b0, w);
        issue(3'b000, 6'b000000, 4'b0010, 1'b0, 1'b1, 1'b0, w);
        check("add_during_busy_wait", w, 0);
        issue(3'b010, 6'b010000, 4'b0100, 1'b0, 1'b1, 1'b0, w);
        check("mfhi_wait", w, int'(NCYC) - 1);

        // Flush during busy leaves busy timing intact
        issue(3'b010, 6'b011001, 4'b1101, 1'b0, 1'b1, 1'b0, w);
        issue(3'b000, 6'b000000, 4'b0010, 1'b0, 1'b0, 1'b1, w);
        @(negedge clk);
        check("busyflush_out_valid", int'(out_valid), 0);
        for (int k = 1; k < int'(NCYC); k++) begin
            if (k > 1) @(negedge clk);
            check("busyflush_busy", int'(muldiv_busy), 1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("busyflush_idle", int'(muldiv_busy), 0);
        @(posedge clk);
        #1;

        // A flushed MULT does not start the sequencer
        issue(3'b010, 6'b011000, 4'b1101, 1'b0, 1'b0, 1'b1, w);
        @(negedge clk);
        check("flushed_mult_busy", int'(muldiv_busy), 0);
        check("flushed_mult_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
`else
        // Without the sequencer DIV is illegal and streams every cycle
        for (int k = 0; k < 3; k++) begin
            issue(3'b010, 6'b011010, 4'b0010, 1'b1, 1'b1, 1'b0, w);
            check("div_b2b_wait", w, 0);
        end
        issue(3'b010, 6'b011000, 4'b0010, 1'b1, 1'b1, 1'b0, w);
        check("mult_b2b_wait", w, 0);
        @(negedge clk);
        check("nomd_busy", int'(muldiv_busy), 0);
        @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
